// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry of the 4x8 register file and
// the packed write-back entry used by the register file and its write queue.
package regfile_pkg;

  localparam int REG_ADDR_W = 2;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_wb_fwd_match.sv
// Forwarding matcher for one decode read port. Walks the pending entries
// from oldest (rd_ptr) to youngest (rd_ptr+count-1); each later match
// overrides the earlier one, so the youngest matching value wins.
module wb_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] query,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // Age-ordered search; data stays zero when nothing matches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             match;
    hit   = 1'b0;
    data  = {DATA_W{1'b0}};
    idx   = {PTR_W{1'b0}};
    match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx   = rd_ptr + PTR_W'(k);
      match = (CNT_W'(k) < count) && valid[idx] && (entries[idx].addr == query);
      hit   = hit | match;
      data  = match ? entries[idx].data : data;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 4x8 register file write port.
// In-order circular buffer, one push and one pop per cycle, flush has
// priority over both. Operand forwarding is compiled in only when
// REGFILE_WB_BYPASS_EN is defined; otherwise the fwd_* outputs are zero
// and decode must stall while the queue is not empty.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              rf_grant,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic      full_s;
  logic      empty_s;
  logic      push_s;
  logic      pop_s;
  wb_entry_t head_s;

  // Full/empty come from count alone, so wr_ptr==rd_ptr is never ambiguous.
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Ready does not look through a same-cycle pop: a full queue refuses.
  assign push_s = in_valid && !full_s && !flush;
  assign pop_s  = !empty_s && rf_grant && !flush;
  assign head_s = mem_r[rd_ptr_r];

  assign in_ready        = !full_s;
  assign empty           = empty_s;
  assign rf_write_enable = pop_s;
  assign rf_write_addr   = head_s.addr;
  assign rf_write_data   = head_s.data;

  // Entry storage: written on accepted push only; contents are never reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_addr, in_data};
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic [DEPTH-1:0] valid_s;

  // Slot i is pending when its distance from the head is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    valid_s = {DEPTH{1'b0}};
    off     = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - rd_ptr_r;
      valid_s[i] = ({1'b0, off} < count_r);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
    .entries (mem_r),
    .valid   (valid_s),
    .rd_ptr  (rd_ptr_r),
    .count   (count_r),
    .query   (q_addr1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
    .entries (mem_r),
    .valid   (valid_s),
    .rd_ptr  (rd_ptr_r),
    .count   (count_r),
    .query   (q_addr2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );
`else
  logic unused_q_s;

  // Without forwarding the read addresses have no consumer.
  assign unused_q_s = ^{q_addr1, q_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = {DATA_W{1'b0}};
  assign fwd_data2  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: table of hand-derived vectors,
// directed multi-cycle sequences and random traffic, all compared against
// a queue-based model of the write-back rules.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, flush, rf_grant, rf_write_enable, empty;
  logic [1:0] in_addr, rf_write_addr, q_addr1, q_addr2;
  logic [7:0] in_data, rf_write_data, fwd_data1, fwd_data2;
  logic       fwd_hit1, fwd_hit2;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH), .ADDR_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .flush(flush), .rf_grant(rf_grant),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .q_addr1(q_addr1), .q_addr2(q_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2), .empty(empty)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [1:0] a; logic [7:0] d; } ent_t;
  ent_t       mq[$];
  logic [7:0] rf_mdl [4];
  logic [7:0] rf_obs [4];
  logic [7:0] wobs[$];

  typedef struct {
    logic v; logic [1:0] a; logic [7:0] d; logic f; logic g;
    logic [1:0] q1; logic [1:0] q2;
    logic we; logic [1:0] wa; logic [7:0] wd;
    logic e; logic r; logic h1; logic [7:0] d1; logic h2; logic [7:0] d2;
  } vec_t;
  vec_t tbl [10];

  // Register file as seen through the DUT write port.
  always @(posedge clk) begin
    if (rf_write_enable) begin
      rf_obs[rf_write_addr] <= rf_write_data;
      wobs.push_back(rf_write_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void fwd_ref(input logic [1:0] q, output logic h, output logic [7:0] d);
    h = 1'b0;
    d = 8'h00;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == q) begin
        h = 1'b1;
        d = mq[i].d;
        break;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [1:0] a, input logic [7:0] d, input logic f,
                       input logic g, input logic [1:0] q1, input logic [1:0] q2);
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = d; flush = f; rf_grant = g;
    q_addr1 = q1; q_addr2 = q2;
    #1;
  endtask

  task automatic check_model();
    logic h; logic [7:0] d;
    chk("ready", in_ready, (mq.size() < DEPTH));
    chk("empty", empty, (mq.size() == 0));
    chk("wen", rf_write_enable, (mq.size() != 0) && rf_grant && !flush);
    if (mq.size() != 0) begin
      chk("waddr", rf_write_addr, mq[0].a);
      chk("wdata", rf_write_data, mq[0].d);
    end
    fwd_ref(q_addr1, h, d);
    chk("hit1", fwd_hit1, BYP ? h : 1'b0);
    chk("fdata1", fwd_data1, BYP ? d : 8'h00);
    fwd_ref(q_addr2, h, d);
    chk("hit2", fwd_hit2, BYP ? h : 1'b0);
    chk("fdata2", fwd_data2, BYP ? d : 8'h00);
  endtask

  task automatic advance();
    bit rdy, we;
    rdy = (mq.size() < DEPTH);
    we  = (mq.size() != 0) && rf_grant && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (we) begin
        rf_mdl[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
      end
      if (in_valid && rdy) mq.push_back('{a: in_addr, d: in_data});
    end
    @(posedge clk);
  endtask

  task automatic cycle(input logic v, input logic [1:0] a, input logic [7:0] d, input logic f,
                       input logic g, input logic [1:0] q1, input logic [1:0] q2);
    drive(v, a, d, f, g, q1, q2);
    check_model();
    advance();
  endtask

  logic [7:0] exp_wr[$];

  initial begin
    for (int i = 0; i < 4; i++) begin rf_mdl[i] = 8'h00; rf_obs[i] = 8'h00; end
    rst = 1'b1; in_valid = 1'b0; in_addr = 2'd0; in_data = 8'h00; flush = 1'b0;
    rf_grant = 1'b0; q_addr1 = 2'd0; q_addr2 = 2'd0;

    //           v     a     d      f     g     q1    q2    we    wa    wd     e     r     h1    d1     h2    d2
    tbl[0] = '{1'b1, 2'd2, 8'h3C, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 2'd1, 8'hA0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 2'd1, 8'hB0, 1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 2'd2, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 8'h3C};
    tbl[3] = '{1'b1, 2'd3, 8'hC3, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd3, 1'b1, 2'd1, 8'hA0, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 8'hC3};
    tbl[5] = '{1'b1, 2'd0, 8'h77, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 2'd0, 8'h12, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 2'd0, 8'h12, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00};
    tbl[9] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

    // reset state
    #12;
    chk("rst_empty", empty, 1'b1);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_wen", rf_write_enable, 1'b0);
    chk("rst_hit1", fwd_hit1, 1'b0);
    chk("rst_fdata1", fwd_data1, 8'h00);
    @(negedge clk); rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].f, tbl[i].g, tbl[i].q1, tbl[i].q2);
      chk($sformatf("tbl%0d_wen", i), rf_write_enable, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_waddr", i), rf_write_addr, tbl[i].wa);
        chk($sformatf("tbl%0d_wdata", i), rf_write_data, tbl[i].wd);
      end
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].r);
      chk($sformatf("tbl%0d_hit1", i), fwd_hit1, BYP ? tbl[i].h1 : 1'b0);
      chk($sformatf("tbl%0d_fdata1", i), fwd_data1, BYP ? tbl[i].d1 : 8'h00);
      chk($sformatf("tbl%0d_hit2", i), fwd_hit2, BYP ? tbl[i].h2 : 1'b0);
      chk($sformatf("tbl%0d_fdata2", i), fwd_data2, BYP ? tbl[i].d2 : 8'h00);
      check_model();
      advance();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("tbl_rf2", rf_obs[2], 8'h3C);
    chk("tbl_rf1", rf_obs[1], 8'hA0);
    chk("tbl_rf0", rf_obs[0], 8'h12);

    // youngest forwarding, then register file holds the younger value
    cycle(1'b1, 2'd1, 8'hA0, 1'b0, 1'b0, 2'd1, 2'd3);
    cycle(1'b1, 2'd1, 8'hB0, 1'b0, 1'b0, 2'd1, 2'd3);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd1, 2'd3);
    chk("yng_hit1", fwd_hit1, BYP);
    chk("yng_fdata1", fwd_data1, BYP ? 8'hB0 : 8'h00);
    chk("yng_hit2", fwd_hit2, 1'b0);
    advance();
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd3);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd3);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd1, 2'd3);
    chk("yng_hit1_after", fwd_hit1, 1'b0);
    chk("yng_rf1", rf_obs[1], 8'hB0);

    // single write latency
    cycle(1'b1, 2'd2, 8'h5A, 1'b0, 1'b1, 2'd0, 2'd0);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 2'd0);
    chk("lat_wen", rf_write_enable, 1'b1);
    chk("lat_waddr", rf_write_addr, 2'd2);
    chk("lat_wdata", rf_write_data, 8'h5A);
    check_model();
    advance();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 2'd0);
    chk("lat_empty", empty, 1'b1);
    chk("lat_rf2", rf_obs[2], 8'h5A);

    // fill and backpressure
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 2'd0, 2'd1);
    wobs.delete();
    drive(1'b1, 2'd0, 8'h55, 1'b0, 1'b0, 2'd0, 2'd1);
    chk("bp_ready_full", in_ready, 1'b0);
    check_model(); advance();
    drive(1'b1, 2'd0, 8'h55, 1'b0, 1'b1, 2'd0, 2'd1);
    chk("bp_ready_pop", in_ready, 1'b0);
    check_model(); advance();
    drive(1'b1, 2'd0, 8'h55, 1'b0, 1'b1, 2'd0, 2'd1);
    chk("bp_ready_back", in_ready, 1'b1);
    check_model(); advance();
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd1);
    exp_wr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    chk("bp_nwrites", wobs.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wobs.size(); i++)
      chk($sformatf("bp_order%0d", i), wobs[i], exp_wr[i]);

    // full queue with simultaneous push/pop and pointer wrap
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 8'(8'h80 + i), 1'b0, 1'b0, 2'd1, 2'd2);
    wobs.delete();
    drive(1'b1, 2'd0, 8'h90, 1'b0, 1'b1, 2'd1, 2'd2);
    chk("wrap_ready_full", in_ready, 1'b0);
    check_model(); advance();
    for (int k = 1; k < 8; k++) cycle(1'b1, 2'(k), 8'(8'h90 + k), 1'b0, 1'b1, 2'd1, 2'd2);
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd2);
    exp_wr = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97};
    chk("wrap_nwrites", wobs.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wobs.size(); i++)
      chk($sformatf("wrap_order%0d", i), wobs[i], exp_wr[i]);

    // flush priority over push and pop
    cycle(1'b1, 2'd1, 8'h61, 1'b0, 1'b0, 2'd1, 2'd2);
    cycle(1'b1, 2'd2, 8'h62, 1'b0, 1'b0, 2'd1, 2'd2);
    wobs.delete();
    drive(1'b1, 2'd3, 8'h63, 1'b1, 1'b1, 2'd1, 2'd2);
    chk("fl_wen", rf_write_enable, 1'b0);
    check_model(); advance();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd3);
    chk("fl_empty", empty, 1'b1);
    check_model(); advance();
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 2'd2);
    chk("fl_nwrites", wobs.size(), 0);

    // asynchronous reset with writes pending
    for (int i = 1; i < 4; i++) cycle(1'b1, 2'(i), 8'(8'hD0 + i), 1'b0, 1'b0, 2'd1, 2'd2);
    @(negedge clk);
    in_valid = 1'b0; rf_grant = 1'b1; q_addr1 = 2'd1; q_addr2 = 2'd2;
    #2 rst = 1'b1;
    #1;
    chk("mrst_empty", empty, 1'b1);
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_wen", rf_write_enable, 1'b0);
    chk("mrst_hit1", fwd_hit1, 1'b0);
    chk("mrst_fdata1", fwd_data1, 8'h00);
    chk("mrst_hit2", fwd_hit2, 1'b0);
    mq.delete();
    wobs.delete();
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd2);
    chk("mrst_nwrites", wobs.size(), 0);

    // random traffic against the model
    begin
      logic v, hold;
      logic [1:0] a;
      logic [7:0] d;
      v = 1'b0; a = 2'd0; d = 8'h00; hold = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if (!hold) begin
          v = ($urandom_range(0, 9) < 7);
          a = 2'($urandom_range(0, 3));
          d = 8'($urandom_range(0, 255));
        end
        drive(v, a, d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 6),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        hold = v && (mq.size() >= DEPTH);
        check_model();
        advance();
      end
    end
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("final_rf%0d", i), rf_obs[i], rf_mdl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
